// File: rtl/ex_result_buffer.sv
// ex_result_buffer
//   Collects results from the two EX-stage result buses. Up to two
//   instructions can arrive per cycle. When both buses are valid, bus 1 is
//   placed ahead of bus 2. The results are held in an in-order FIFO and are
//   presented to writeback one per cycle under a valid/ready handshake. The
//   head entry is read straight from storage (first-word fall-through).
//
// Ports
//   clock, reset          system clock; synchronous active-high reset
//   ex_*_in_1 / ex_*_in_2 EX result buses: IR, NPC, dest reg, result, valid
//   wb_ready              consumer takes the head entry this cycle
//   wb_*_out              head entry fields; wb_valid_out = (count != 0)
//   ex_stall_out          fewer than two free slots; EX must hold off
//   overflow              sticky flag: at least one write was dropped
//   count_out             current occupancy
module ex_result_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      ex_IR_in_1,
    input  logic [63:0]      ex_NPC_in_1,
    input  logic [4:0]       ex_dest_reg_in_1,
    input  logic [63:0]      ex_result_in_1,
    input  logic             ex_valid_in_1,
    input  logic [31:0]      ex_IR_in_2,
    input  logic [63:0]      ex_NPC_in_2,
    input  logic [4:0]       ex_dest_reg_in_2,
    input  logic [63:0]      ex_result_in_2,
    input  logic             ex_valid_in_2,
    input  logic             wb_ready,
    output logic [31:0]      wb_IR_out,
    output logic [63:0]      wb_NPC_out,
    output logic [4:0]       wb_dest_reg_out,
    output logic [63:0]      wb_result_out,
    output logic             wb_valid_out,
    output logic             ex_stall_out,
    output logic             overflow,
    output logic [CNT_W-1:0] count_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    typedef struct packed {
        logic [31:0] ir;
        logic [63:0] npc;
        logic [4:0]  dest;
        logic [63:0] result;
    } entry_t;

    entry_t mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [CNT_W-1:0] free_slots;
    logic [CNT_W-1:0] nwrites;
    logic             pop;
    logic             wr0_en, wr1_en;
    entry_t           wr0_data, wr1_data;
    entry_t           bus1, bus2;

    assign bus1 = {ex_IR_in_1, ex_NPC_in_1, ex_dest_reg_in_1, ex_result_in_1};
    assign bus2 = {ex_IR_in_2, ex_NPC_in_2, ex_dest_reg_in_2, ex_result_in_2};

    // Free space is computed from the registered count only. A same-cycle
    // pop therefore never creates room for a write, and ex_stall_out has no
    // combinational path from the bus valids or from wb_ready.
    assign free_slots = CNT_DEPTH - count_q;

    always_comb begin
        pop        = (count_q != '0) & wb_ready;
        wr0_en     = 1'b0;
        wr1_en     = 1'b0;
        wr0_data   = bus1;
        wr1_data   = bus2;
        overflow_d = overflow_q;

        // Write slot 0 lands at the tail and write slot 1 at tail+1. When a
        // lone bus 2 write arrives, it moves into slot 0.
        if (ex_valid_in_1 && ex_valid_in_2) begin
            wr0_en = (free_slots >= CNT_ONE);
            wr1_en = (free_slots >= CNT_TWO);
            if (free_slots < CNT_TWO) overflow_d = 1'b1;
        end else if (ex_valid_in_1 || ex_valid_in_2) begin
            if (ex_valid_in_2) wr0_data = bus2;
            wr0_en = (free_slots != '0);
            if (free_slots == '0) overflow_d = 1'b1;
        end

        nwrites = CNT_W'(wr0_en) + CNT_W'(wr1_en);
        tail_d  = tail_q + PTR_W'(nwrites);
        head_d  = head_q + PTR_W'(pop);
        count_d = count_q + nwrites - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // The storage array has no reset. Stale entries are never visible
    // because wb_valid_out is derived from the count.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wr0_en) mem_q[tail_q] <= wr0_data;
            if (wr1_en) mem_q[tail_q + PTR_W'(1)] <= wr1_data;
        end
    end

    assign {wb_IR_out, wb_NPC_out, wb_dest_reg_out, wb_result_out} = mem_q[head_q];
    assign wb_valid_out = (count_q != '0);
    assign ex_stall_out = (free_slots < CNT_TWO);
    assign overflow     = overflow_q;
    assign count_out    = count_q;

endmodule

// File: tb/tb_ex_result_buffer.sv
module tb_ex_result_buffer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [31:0] ir1 = '0, ir2 = '0;
    logic [63:0] npc1 = '0, npc2 = '0, res1 = '0, res2 = '0;
    logic [4:0]  dst1 = '0, dst2 = '0;
    logic        v1 = 1'b0, v2 = 1'b0, wb_ready = 1'b0;
    logic [31:0] wb_IR_out;
    logic [63:0] wb_NPC_out, wb_result_out;
    logic [4:0]  wb_dest_reg_out;
    logic        wb_valid_out, ex_stall_out, overflow;
    logic [CNT_W-1:0] count_out;

    ex_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .ex_IR_in_1(ir1), .ex_NPC_in_1(npc1), .ex_dest_reg_in_1(dst1),
        .ex_result_in_1(res1), .ex_valid_in_1(v1),
        .ex_IR_in_2(ir2), .ex_NPC_in_2(npc2), .ex_dest_reg_in_2(dst2),
        .ex_result_in_2(res2), .ex_valid_in_2(v2),
        .wb_ready(wb_ready),
        .wb_IR_out(wb_IR_out), .wb_NPC_out(wb_NPC_out),
        .wb_dest_reg_out(wb_dest_reg_out), .wb_result_out(wb_result_out),
        .wb_valid_out(wb_valid_out), .ex_stall_out(ex_stall_out),
        .overflow(overflow), .count_out(count_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] ir;
        logic [63:0] npc;
        logic [4:0]  dest;
        logic [63:0] result;
    } ent_t;

    ent_t mq[$];
    bit   m_ovf = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue with a capacity limit. The free space is
    // taken before any pop, and writes are offered bus 1 first.
    task automatic model_edge();
        int   free;
        bit   do_pop;
        ent_t w[$];
        ent_t e;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            free   = DEPTH - mq.size();
            do_pop = (mq.size() != 0) && wb_ready;
            if (v1) begin e.ir = ir1; e.npc = npc1; e.dest = dst1; e.result = res1; w.push_back(e); end
            if (v2) begin e.ir = ir2; e.npc = npc2; e.dest = dst2; e.result = res2; w.push_back(e); end
            foreach (w[i]) begin
                if (free > 0) begin mq.push_back(w[i]); free--; end
                else m_ovf = 1'b1;
            end
            if (do_pop) void'(mq.pop_front());
        end
    endtask

    task automatic compare_all();
        int n;
        n = mq.size();
        chk("wb_valid", wb_valid_out, n != 0);
        chk("count", count_out, n);
        chk("stall", ex_stall_out, (DEPTH - n) < 2);
        chk("overflow", overflow, m_ovf);
        if (n != 0) begin
            chk("head_ir", wb_IR_out, mq[0].ir);
            chk("head_npc", wb_NPC_out, mq[0].npc);
            chk("head_dest", wb_dest_reg_out, mq[0].dest);
            chk("head_result", wb_result_out, mq[0].result);
        end
    endtask

    // One clock: compare on the falling edge, advance the model on the
    // rising edge, and return 1 time unit later so inputs can change.
    task automatic step();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input int b, input bit v, input logic [4:0] d, input logic [63:0] r);
        if (b == 1) begin
            v1 = v; dst1 = d; res1 = r; ir1 = {16'hC0DE, r[15:0]}; npc1 = r + 64'h1000;
        end else begin
            v2 = v; dst2 = d; res2 = r; ir2 = {16'hBEEF, r[15:0]}; npc2 = r + 64'h2000;
        end
    endtask

    task automatic idle();
        v1 = 1'b0;
        v2 = 1'b0;
    endtask

    logic [63:0] popped [20];
    logic [63:0] last_res;
    int          seen_b2;

    initial begin
        // 1: reset, then idle
        reset = 1'b1; step(); step();
        reset = 1'b0; step();
        chk("t1_valid", wb_valid_out, 1'b0);
        chk("t1_stall", ex_stall_out, 1'b0);
        chk("t1_count", count_out, 0);
        chk("t1_ovf", overflow, 1'b0);

        // 2: both buses in one cycle, then drain
        drive(1, 1, 5'd3, 64'h11); drive(2, 1, 5'd4, 64'h22); wb_ready = 1'b0;
        step(); idle();
        chk("t2_count", count_out, 2);
        chk("t2_head_dest", wb_dest_reg_out, 3);
        chk("t2_head_res", wb_result_out, 64'h11);
        wb_ready = 1'b1; step();
        chk("t2_second_dest", wb_dest_reg_out, 4);
        chk("t2_second_res", wb_result_out, 64'h22);
        step();
        chk("t2_empty", wb_valid_out, 1'b0);
        wb_ready = 1'b0;

        // 3: only bus 2 valid into an empty buffer
        drive(2, 1, 5'd7, 64'h77); step(); idle();
        chk("t3_dest", wb_dest_reg_out, 7);
        chk("t3_count", count_out, 1);
        wb_ready = 1'b1; step(); wb_ready = 1'b0;

        // 4: fill to 6, then 7 and 8; stall threshold
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'(k), 64'h40 + 64'(2*k)); drive(2, 1, 5'(k+8), 64'h41 + 64'(2*k));
            step();
        end
        idle(); step();
        chk("t4_count6", count_out, 6);
        chk("t4_stall6", ex_stall_out, 1'b0);
        drive(1, 1, 5'd20, 64'h46); step(); idle();
        chk("t4_count7", count_out, 7);
        chk("t4_stall7", ex_stall_out, 1'b1);
        drive(1, 1, 5'd21, 64'h47); step(); idle();
        chk("t4_stall8", ex_stall_out, 1'b1);
        wb_ready = 1'b1; step(); wb_ready = 1'b0;
        chk("t4_count_after_pop", count_out, 7);
        chk("t4_stall_after_pop", ex_stall_out, 1'b1);

        // 5: both buses at count 7; bus 1 kept and bus 2 dropped
        drive(1, 1, 5'd30, 64'hB1); drive(2, 1, 5'd31, 64'hB2);
        step(); idle();
        chk("t5_count", count_out, 8);
        chk("t5_ovf", overflow, 1'b1);
        wb_ready = 1'b1; seen_b2 = 0; last_res = '0;
        for (int k = 0; k < 8; k++) begin
            last_res = wb_result_out;
            if (wb_result_out == 64'hB2) seen_b2++;
            step();
        end
        wb_ready = 1'b0;
        chk("t5_last_is_bus1", last_res, 64'hB1);
        chk("t5_bus2_never_seen", seen_b2, 0);
        chk("t5_drained", wb_valid_out, 1'b0);
        chk("t5_ovf_sticky", overflow, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t5_ovf_cleared", overflow, 1'b0);

        // 6: wrap with a simultaneous write and pop at count 3
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 5'(k), 64'(k)); step();
        end
        wb_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 5'(k + 3), 64'(k + 3));
            popped[k] = wb_result_out;
            step();
        end
        chk("t6_count_steady", count_out, 3);
        for (int k = 0; k < 20; k++) chk("t6_pop_seq", popped[k], 64'(k));
        // reset mid-stream while a write and a pop are both pending
        reset = 1'b1; step(); reset = 1'b0; idle(); wb_ready = 1'b0;
        chk("t6_reset_count", count_out, 0);
        chk("t6_reset_valid", wb_valid_out, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
